// File: rtl/lia_sched_pkg.sv
// Shared constants for the lock-in snapshot scheduler.
//   - Avalon-MM word addresses of the control/status registers and the
//     base address of the per-channel X/Y snapshot words
//   - NCH_MAX: the largest channel count the register map has room for;
//     it is also the bit offset of the OVR field inside STATUS
//   - state_e: scheduler FSM encoding
package lia_sched_pkg;

    localparam int NCH_MAX = 8;

    localparam logic [4:0] ADDR_CTRL    = 5'd0;
    localparam logic [4:0] ADDR_STATUS  = 5'd1;
    localparam logic [4:0] ADDR_CHAN_EN = 5'd2;
    localparam logic [4:0] ADDR_IRQCLR  = 5'd3;

    // X[i] sits at ADDR_DATA_BASE + 2*i and Y[i] at ADDR_DATA_BASE + 2*i + 1.
    localparam int ADDR_DATA_BASE = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ARMED = 2'd1,
        SWAP  = 2'd2
    } state_e;

endpackage

// File: rtl/lia_rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
//   clk, reset : clock and asynchronous active-high reset
//   req[N]     : request vector
//   advance    : 0 suppresses the grant (and leaves the pointer untouched)
//   gnt[N]     : one-hot grant, or all-zero when nothing is requested
// The search starts at the channel just after the last one granted and
// wraps around, so every requester is served within N grants.
module lia_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [N-1:0]  pick;
    logic          found;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through the block can leave it holding its old value (no latch).
        pick     = '0;
        found    = 1'b0;
        ptr_next = ptr;
        // First pass: requesters at or above the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                pick[i]  = 1'b1;
                found    = 1'b1;
                ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        // Second pass: wrap around to the requesters below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                pick[i]  = 1'b1;
                found    = 1'b1;
                ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        gnt = advance ? pick : '0;
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/lia_snapshot_scheduler.sv
// Lock-in snapshot scheduler: gathers X/Y results from NCH lock-in channels
// into a double-buffered bank so the CPU always reads a coherent snapshot.
//   clk, reset       : clock, asynchronous active-high reset
//   lia_x, lia_y     : NCH packed signed W-bit samples, channel i at [i*W +: W]
//   lia_valid        : per-channel 1-cycle strobe
//   avs_*            : Avalon-MM slave (5-bit word address, 32-bit data),
//                      readdata registered with fixed 1-cycle latency
//   irq              : level interrupt, swap done (irq_pend & CTRL.irq_en)
// Strobed samples wait in a per-channel hold register until the arbiter
// copies them into the write bank (~bank_sel). A swap flips bank_sel so the
// freshly written bank becomes the one the CPU reads.
module lia_snapshot_scheduler
    import lia_sched_pkg::*;
#(
    parameter int NCH = 8,
    parameter int W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH*W-1:0] lia_x,
    input  logic [NCH*W-1:0] lia_y,
    input  logic [NCH-1:0]   lia_valid,
    input  logic [4:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] ovr;
    logic [NCH-1:0] upd;
    logic [NCH-1:0] chan_en;
    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] ovr_clr;

    logic signed [W-1:0] hold_x [NCH];
    logic signed [W-1:0] hold_y [NCH];
    logic signed [W-1:0] bank_x [2][NCH];
    logic signed [W-1:0] bank_y [2][NCH];

    logic        bank_sel;
    logic        bank_wr;
    logic [15:0] seq;
    logic        ctrl_auto;
    logic        ctrl_irq_en;
    logic        ctrl_wait_all;
    logic        irq_pend;

    state_e      state;
    state_e      state_next;
    logic        in_swap;
    logic        armed;
    logic        done;
    logic        snap_req;

    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_chan_en;
    logic        wr_irqclr;
    logic [31:0] read_mux;
    logic        unused_wdata;

    assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
    assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
    assign wr_chan_en = avs_write && (avs_address == ADDR_CHAN_EN);
    assign wr_irqclr  = avs_write && (avs_address == ADDR_IRQCLR);
    assign snap_req   = wr_ctrl && avs_writedata[0];

    // A snapshot is complete once every enabled channel has been updated;
    // with no channel enabled it is trivially complete.
    assign done    = &(upd | ~chan_en);
    assign bank_wr = ~bank_sel;
    assign req     = pending & chan_en;

    // A strobe onto an already-pending channel overwrites unread data, unless
    // that channel is being granted this very cycle (old data leaves as new
    // data arrives).
    assign ovr_set = lia_valid & chan_en & pending & ~gnt;
    assign ovr_clr = wr_status ? avs_writedata[NCH_MAX +: NCH] : '0;

    assign irq          = irq_pend & ctrl_irq_en;
    assign unused_wdata = ^avs_writedata;

    lia_rr_arbiter #(.N(NCH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (!in_swap),
        .gnt     (gnt)
    );

    // Scheduler FSM: next state and per-state outputs.
    always_comb begin
        state_next = state;
        in_swap    = 1'b0;
        armed      = 1'b0;
        case (state)
            RUN: begin
                if (snap_req) begin
                    state_next = ARMED;
                end else if (ctrl_auto && done && (chan_en != '0)) begin
                    state_next = SWAP;
                end
            end
            ARMED: begin
                armed = 1'b1;
                if (!ctrl_wait_all || done) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                in_swap    = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Capture into hold registers, arbiter copy into the write bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ovr     <= '0;
            upd     <= '0;
            // NOTE: the banks are small flop arrays, not RAM, so they are reset:
            // a snapshot read before the first swap must return 0.
            for (int i = 0; i < NCH; i++) begin
                hold_x[i]    <= '0;
                hold_y[i]    <= '0;
                bank_x[0][i] <= '0;
                bank_x[1][i] <= '0;
                bank_y[0][i] <= '0;
                bank_y[1][i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!chan_en[i]) begin
                    pending[i] <= 1'b0;
                end else if (lia_valid[i]) begin
                    hold_x[i]  <= lia_x[i*W +: W];
                    hold_y[i]  <= lia_y[i*W +: W];
                    pending[i] <= 1'b1;
                end else if (gnt[i]) begin
                    pending[i] <= 1'b0;
                end
                if (gnt[i]) begin
                    bank_x[bank_wr][i] <= hold_x[i];
                    bank_y[bank_wr][i] <= hold_y[i];
                end
            end
            // A fresh overrun in the same cycle as its W1C keeps the flag set.
            ovr <= (ovr & ~ovr_clr) | ovr_set;
            upd <= in_swap ? '0 : (upd | gnt);
        end
    end

    // FSM state, bank selection, control registers and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            bank_sel      <= 1'b0;
            seq           <= '0;
            ctrl_auto     <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_wait_all <= 1'b0;
            irq_pend      <= 1'b0;
            chan_en       <= '1;
            avs_readdata  <= '0;
        end else begin
            state <= state_next;
            if (in_swap) begin
                bank_sel <= ~bank_sel;
                seq      <= seq + 16'd1;
            end
            // A swap outranks a simultaneous IRQCLR so no swap event is lost.
            if (in_swap) begin
                irq_pend <= 1'b1;
            end else if (wr_irqclr) begin
                irq_pend <= 1'b0;
            end
            if (wr_ctrl) begin
                ctrl_auto     <= avs_writedata[1];
                ctrl_irq_en   <= avs_writedata[2];
                ctrl_wait_all <= avs_writedata[3];
            end
            if (wr_chan_en) begin
                chan_en <= avs_writedata[NCH-1:0];
            end
            if (avs_read) begin
                avs_readdata <= read_mux;
            end
        end
    end

    // Read decode. Values come from the current (pre-edge) registers, so a
    // STATUS read in the SWAP cycle still sees the pre-swap SEQ/UPD.
    always_comb begin
        read_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                read_mux[0] = armed;
                read_mux[1] = ctrl_auto;
                read_mux[2] = ctrl_irq_en;
                read_mux[3] = ctrl_wait_all;
                read_mux[4] = irq_pend;
            end
            ADDR_STATUS: begin
                read_mux[NCH-1:0]        = upd;
                read_mux[NCH_MAX +: NCH] = ovr;
                read_mux[31:16]          = seq;
            end
            ADDR_CHAN_EN: begin
                read_mux[NCH-1:0] = chan_en;
            end
            default: begin
                // Signed operands, so the size cast sign-extends to 32 bits.
                for (int i = 0; i < NCH; i++) begin
                    if (avs_address == 5'(ADDR_DATA_BASE + 2*i)) begin
                        read_mux = 32'(bank_x[bank_sel][i]);
                    end else if (avs_address == 5'(ADDR_DATA_BASE + 2*i + 1)) begin
                        read_mux = 32'(bank_y[bank_sel][i]);
                    end
                end
            end
        endcase
    end

endmodule
